btpipe_block_source: RTL and testbench

- Synthesizable initiator for the block-throttled pipe-in handshake: drives a block strobe, write strobes and 16-bit data into a block-throttled receiver.
- Generates a pseudorandom (LFSR) or counter data sequence, so the receiver-side checker can be exercised on-chip without the host.
- Used for loopback self-test and for throughput benchmarking of the pipe-in checker path.
- Runs in the ti_clk domain.

---
 rtl/pipe_test_pkg.sv | 29 ++
 rtl/btpipe_block_source_if.sv | 25 ++
 rtl/pipe_pattern_gen.sv | 35 +++
 rtl/btpipe_block_source.sv | 133 +++++++++++++
 tb/tb_btpipe_block_source.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_test_pkg.sv
// Shared definitions for the block-throttled pipe test source and checker.
// Holds the FSM state encoding, pattern mode encodings, LFSR taps and the
// default throttle, plus the single pattern-advance function both ends use.
package pipe_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_STROBE,
    ST_GAP,
    ST_WRITE,
    ST_FINISH
  } state_t;

  // Taps at bits 31, 21, 1 and 0.
  localparam logic [31:0] LFSR_TAPS        = 32'h8020_0003;
  localparam logic        MODE_LFSR        = 1'b0;
  localparam logic        MODE_COUNT       = 1'b1;
  localparam logic [31:0] THROTTLE_DEFAULT = 32'hFFFF_FFFF;

  // Counter mode wraps in the low 16 bits only; the upper half is untouched.
  function automatic logic [31:0] pattern_next(input logic [31:0] s, input logic m);
    if (m == MODE_COUNT) begin
      return {s[31:16], s[15:0] + 16'd1};
    end
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/btpipe_block_source_if.sv
// Block-throttled pipe-in link between a source (master) and a receiver (slave).
// Latency: wires only.
// Backpressure: ep_ready grants one whole block; there is no per-word stall.
// Signals: ep_ready (receiver can take a block), ep_blockstrobe (block
// header pulse), ep_write (data valid), ep_dataout (16-bit data word).
interface btpipe_block_source_if;
  logic        ep_ready;
  logic        ep_blockstrobe;
  logic        ep_write;
  logic [15:0] ep_dataout;

  modport master (
    input  ep_ready,
    output ep_blockstrobe,
    output ep_write,
    output ep_dataout
  );

  modport slave (
    output ep_ready,
    input  ep_blockstrobe,
    input  ep_write,
    input  ep_dataout
  );
endinterface

// File: rtl/pipe_pattern_gen.sv
// Test pattern generator: 32-bit LFSR or 16-bit wrapping counter.
// Latency: word reflects the register directly; advance/load act on the next edge.
// Backpressure: none; the caller decides when to advance.
// Ports: clk/reset, load (seed+mode capture), seed, mode, advance, word.
module pipe_pattern_gen
  import pipe_test_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        mode,
  input  logic        advance,
  output logic [15:0] word
);

  logic [31:0] pat_q;
  logic        mode_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q  <= '0;
      mode_q <= MODE_LFSR;
    end else if (load) begin
      // An all-zero LFSR would lock up, so a zero seed becomes 1.
      pat_q  <= (mode == MODE_LFSR && seed == 32'd0) ? 32'd1 : seed;
      mode_q <= mode;
    end else if (advance) begin
      pat_q <= pattern_next(pat_q, mode_q);
    end
  end

  assign word = pat_q[15:0];

endmodule

// File: rtl/btpipe_block_source.sv
// Block-throttled pipe-in initiator generating LFSR/counter data blocks.
// Latency: start to first strobe is 2 cycles with ep_ready high; done trails FINISH by 1 cycle.
// Backpressure: ep_ready is sampled once per block in WAIT_RDY; a started block always completes.
// Ports: clk, reset, start/num_blocks/seed/mode (transfer setup),
// throttle_set/throttle_val (write-enable rotation), ep (pipe link master),
// busy, done, words_sent (status).
module btpipe_block_source
  import pipe_test_pkg::*;
#(
  parameter int BLOCK_WORDS = 256,
  parameter int STROBE_GAP  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] num_blocks,
  input  logic [31:0] seed,
  input  logic        mode,
  input  logic        throttle_set,
  input  logic [31:0] throttle_val,
  btpipe_block_source_if.master ep,
  output logic        busy,
  output logic        done,
  output logic [31:0] words_sent
);

  localparam logic [9:0] IDX_LAST = 10'(BLOCK_WORDS - 1);
  localparam logic [3:0] GAP_LAST = 4'((STROBE_GAP > 0) ? STROBE_GAP - 1 : 0);

  state_t      state_q, state_d;
  logic        busy_q, done_q;
  logic [15:0] blocks_left;
  logic [9:0]  word_idx;
  logic [3:0]  gap_cnt;
  logic [31:0] throttle_q;
  logic [31:0] words_sent_q;
  logic [15:0] dout_q;
  logic [15:0] pat_word;

  logic accept, strobe, write_en, blk_end;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    strobe   = 1'b0;
    write_en = 1'b0;
    blk_end  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // busy is still high during the done cycle, so a start there is ignored.
        if (start && !busy_q) begin
          accept  = 1'b1;
          state_d = (num_blocks == 16'd0) ? ST_FINISH : ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (ep.ep_ready) state_d = ST_STROBE;
      end
      ST_STROBE: begin
        strobe  = 1'b1;
        state_d = (STROBE_GAP > 0) ? ST_GAP : ST_WRITE;
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        write_en = throttle_q[0];
        if (throttle_q[0] && word_idx == IDX_LAST) begin
          blk_end = 1'b1;
          state_d = (blocks_left == 16'd1) ? ST_FINISH : ST_WAIT_RDY;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      blocks_left  <= '0;
      word_idx     <= '0;
      gap_cnt      <= '0;
      throttle_q   <= THROTTLE_DEFAULT;
      words_sent_q <= '0;
      dout_q       <= '0;
    end else begin
      state_q <= state_d;
      // busy covers the FINISH cycle and the following done cycle.
      busy_q  <= (state_d != ST_IDLE) || (state_q == ST_FINISH);
      done_q  <= (state_q == ST_FINISH);

      if (accept)       blocks_left <= num_blocks;
      else if (blk_end) blocks_left <= blocks_left - 16'd1;

      if (strobe)        word_idx <= '0;
      else if (write_en) word_idx <= word_idx + 10'd1;

      if (strobe)                 gap_cnt <= '0;
      else if (state_q == ST_GAP) gap_cnt <= gap_cnt + 4'd1;

      // A load overrides the rotation that would happen in the same cycle.
      if (throttle_set)            throttle_q <= throttle_val;
      else if (state_q == ST_WRITE) throttle_q <= {throttle_q[0], throttle_q[31:1]};

      if (accept) words_sent_q <= '0;
      else if (write_en && words_sent_q != 32'hFFFF_FFFF) words_sent_q <= words_sent_q + 32'd1;

      if (write_en) dout_q <= pat_word;
    end
  end

  pipe_pattern_gen u_pattern (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .seed    (seed),
    .mode    (mode),
    .advance (write_en),
    .word    (pat_word)
  );

  assign ep.ep_blockstrobe = strobe;
  assign ep.ep_write       = write_en;
  // Between writes the last written word is held on the bus.
  assign ep.ep_dataout     = write_en ? pat_word : dout_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign words_sent        = words_sent_q;

endmodule

// File: tb/tb_btpipe_block_source.sv
module tb_btpipe_block_source;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_blocks = '0;
  logic [31:0] seed = '0;
  logic        mode = 1'b0;
  logic        throttle_set = 1'b0;
  logic [31:0] throttle_val = '0;
  logic        busy, done;
  logic [31:0] words_sent;

  btpipe_block_source_if ep_if ();

  btpipe_block_source #(.BLOCK_WORDS(4), .STROBE_GAP(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_blocks   (num_blocks),
    .seed         (seed),
    .mode         (mode),
    .throttle_set (throttle_set),
    .throttle_val (throttle_val),
    .ep           (ep_if),
    .busy         (busy),
    .done         (done),
    .words_sent   (words_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [31:0] seed;
    logic [15:0] nblk;
    logic        set_thr;
    logic [31:0] thr;
    int          exp_strobes;
    int          exp_words;
    logic [15:0] w0, w1, w2, w3;
    logic [15:0] exp_last;
    int          exp_span;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];

  int n_pass = 0;
  int n_total = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor
  logic [15:0] wq[$];
  int          wcyc[$];
  int          m_strobes = 0;
  int          m_dones = 0;
  int          m_hold_err = 0;

  always @(negedge clk) begin
    if (ep_if.ep_blockstrobe) m_strobes++;
    if (done) m_dones++;
    if (ep_if.ep_write) begin
      wq.push_back(ep_if.ep_dataout);
      wcyc.push_back(cyc);
    end else if (wq.size() > 0 && ep_if.ep_dataout !== wq[$]) begin
      m_hold_err++;
    end
  end

  task automatic mon_clear();
    wq.delete();
    wcyc.delete();
    m_strobes  = 0;
    m_dones    = 0;
    m_hold_err = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [15:0] qget(input int k);
    if (k < wq.size()) return wq[k];
    return 16'hxxxx;
  endfunction

  task automatic start_xfer(input logic m, input logic [31:0] s, input logic [15:0] nb);
    @(negedge clk);
    mode = m; seed = s; num_blocks = nb; start = 1'b1;
    @(negedge clk);
    // Scramble setup inputs so any late sampling shows up in the data.
    start = 1'b0; mode = ~m; seed = 32'hDEAD_BEEF; num_blocks = 16'd7;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (m_dones == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (m_dones == 0) chk({name, "_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input int i);
    vec_t v = vecs[i];
    int span;
    mon_clear();
    if (v.set_thr) begin
      @(negedge clk);
      throttle_set = 1'b1; throttle_val = v.thr;
      @(negedge clk);
      throttle_set = 1'b0;
    end
    start_xfer(v.mode, v.seed, v.nblk);
    wait_done($sformatf("v%0d", i));
    span = (wcyc.size() >= 4) ? wcyc[3] - wcyc[0] + 1 : -1;
    chk($sformatf("v%0d_strobes", i), m_strobes, v.exp_strobes);
    chk($sformatf("v%0d_nwrites", i), wq.size(), v.exp_words);
    chk($sformatf("v%0d_word0", i), qget(0), v.w0);
    chk($sformatf("v%0d_word1", i), qget(1), v.w1);
    chk($sformatf("v%0d_word2", i), qget(2), v.w2);
    chk($sformatf("v%0d_word3", i), qget(3), v.w3);
    chk($sformatf("v%0d_last", i), qget(v.exp_words - 1), v.exp_last);
    chk($sformatf("v%0d_span", i), span, v.exp_span);
    chk($sformatf("v%0d_words_sent", i), words_sent, v.exp_words);
    chk($sformatf("v%0d_dones", i), m_dones, 1);
    chk($sformatf("v%0d_hold", i), m_hold_err, 0);
    chk($sformatf("v%0d_busy_end", i), busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n, st_cnt, wr_cnt, busy_low;

    vecs[0] = '{mode:1'b1, seed:32'h0000_0100, nblk:16'd2, set_thr:1'b0, thr:32'h0,
                exp_strobes:2, exp_words:8, w0:16'h0100, w1:16'h0101, w2:16'h0102, w3:16'h0103,
                exp_last:16'h0107, exp_span:4};
    vecs[1] = '{mode:1'b0, seed:32'h0000_0001, nblk:16'd1, set_thr:1'b1, thr:32'hFFFF_FFFF,
                exp_strobes:1, exp_words:4, w0:16'h0001, w1:16'h0003, w2:16'h0006, w3:16'h000D,
                exp_last:16'h000D, exp_span:4};
    vecs[2] = '{mode:1'b0, seed:32'h0000_0000, nblk:16'd1, set_thr:1'b1, thr:32'hFFFF_FFFF,
                exp_strobes:1, exp_words:4, w0:16'h0001, w1:16'h0003, w2:16'h0006, w3:16'h000D,
                exp_last:16'h000D, exp_span:4};
    vecs[3] = '{mode:1'b1, seed:32'h0001_FFFE, nblk:16'd1, set_thr:1'b1, thr:32'hFFFF_FFFF,
                exp_strobes:1, exp_words:4, w0:16'hFFFE, w1:16'hFFFF, w2:16'h0000, w3:16'h0001,
                exp_last:16'h0001, exp_span:4};
    vecs[4] = '{mode:1'b1, seed:32'h0000_0010, nblk:16'd1, set_thr:1'b1, thr:32'h5555_5555,
                exp_strobes:1, exp_words:4, w0:16'h0010, w1:16'h0011, w2:16'h0012, w3:16'h0013,
                exp_last:16'h0013, exp_span:7};
    vecs[5] = '{mode:1'b0, seed:32'h0000_0001, nblk:16'd2, set_thr:1'b1, thr:32'hFFFF_FFFF,
                exp_strobes:2, exp_words:8, w0:16'h0001, w1:16'h0003, w2:16'h0006, w3:16'h000D,
                exp_last:16'h00DB, exp_span:4};

    ep_if.ep_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_strobe", ep_if.ep_blockstrobe, 0);
    chk("rst_write", ep_if.ep_write, 0);
    chk("rst_dataout", ep_if.ep_dataout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_words_sent", words_sent, 0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Ready stall between blocks; ep_ready dropped mid-block 1
    mon_clear();
    start_xfer(1'b1, 32'h0, 16'd2);
    n = 0;
    while (!ep_if.ep_blockstrobe && n < 100) begin @(negedge clk); n++; end
    chk("stall_first_strobe", ep_if.ep_blockstrobe, 1);
    ep_if.ep_ready = 1'b0;
    n = 0;
    while (words_sent < 4 && n < 100) begin @(negedge clk); n++; end
    chk("stall_blk1_words", words_sent, 4);
    chk("stall_blk1_span", (wcyc.size() >= 4) ? wcyc[3] - wcyc[0] + 1 : -1, 4);
    st_cnt = 0; wr_cnt = 0; busy_low = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ep_if.ep_blockstrobe) st_cnt++;
      if (ep_if.ep_write) wr_cnt++;
      if (!busy) busy_low++;
    end
    chk("stall_no_strobe", st_cnt, 0);
    chk("stall_no_write", wr_cnt, 0);
    chk("stall_busy_held", busy_low, 0);
    ep_if.ep_ready = 1'b1;
    @(negedge clk);
    chk("stall_strobe_after_ready", ep_if.ep_blockstrobe, 1);
    wait_done("stall");
    chk("stall_words_sent", words_sent, 8);
    chk("stall_last_word", qget(7), 16'h0007);
    chk("stall_dones", m_dones, 1);

    // Zero blocks
    mon_clear();
    @(negedge clk);
    mode = 1'b1; seed = 32'h55; num_blocks = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_c1_busy", busy, 1);
    chk("zero_c1_done", done, 0);
    @(negedge clk);
    chk("zero_c2_busy", busy, 1);
    chk("zero_c2_done", done, 1);
    @(negedge clk);
    chk("zero_c3_busy", busy, 0);
    chk("zero_c3_done", done, 0);
    repeat (3) @(negedge clk);
    chk("zero_strobes", m_strobes, 0);
    chk("zero_writes", wq.size(), 0);

    // Asynchronous reset during the third word
    mon_clear();
    start_xfer(1'b1, 32'h0000_0200, 16'd1);
    n = 0;
    while (words_sent < 2 && n < 100) begin @(negedge clk); n++; end
    chk("arst_pre_write", ep_if.ep_write, 1);
    chk("arst_pre_data", ep_if.ep_dataout, 16'h0202);
    #1 reset = 1'b1;
    #1;
    chk("arst_write", ep_if.ep_write, 0);
    chk("arst_busy", busy, 0);
    chk("arst_strobe", ep_if.ep_blockstrobe, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("arst_no_done", m_dones, 0);
    chk("arst_words_sent", words_sent, 0);
    mon_clear();
    start_xfer(1'b1, 32'h0000_0300, 16'd1);
    wait_done("arst_restart");
    chk("arst_restart_word0", qget(0), 16'h0300);
    chk("arst_restart_word3", qget(3), 16'h0303);
    chk("arst_restart_words", words_sent, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
